// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared types and constants for the adder-chain blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Upstream adder result is an 8-bit sum plus its carry bit
    localparam int unsigned c_SAMPLE_WIDTH = 9;

endpackage
`default_nettype wire

// File: rtl/sum_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : sum_accumulator_if
// Description : Sample-in / batch-out handshake bundle of the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface sum_accumulator_if
    import adder_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic [c_SAMPLE_WIDTH-2:0]   sum;
    logic                        carryout;
    logic                        clear;
    logic [ACC_WIDTH-1:0]        result;
    logic                        overflow;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output in_valid, sum, carryout, clear, out_ready,
        input  in_ready, result, overflow, out_valid
    );

    modport slave (
        input  in_valid, sum, carryout, clear, out_ready,
        output in_ready, result, overflow, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/sat_add.sv
`default_nettype none
// ============================================================================
// Module      : sat_add
// Description : Combinational unsigned add that clamps at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_add #(
    parameter int unsigned ACC_WIDTH = 16
) (
    input  wire logic [ACC_WIDTH-1:0] i_a,
    input  wire logic [ACC_WIDTH-1:0] i_b,
    output logic      [ACC_WIDTH-1:0] sum,
    output logic                      sat
);
    logic [ACC_WIDTH:0] w_full;

    // One extra bit catches the carry that signals saturation
    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign sat    = w_full[ACC_WIDTH];
    assign sum    = sat ? {ACC_WIDTH{1'b1}} : w_full[ACC_WIDTH-1:0];
endmodule
`default_nettype wire

// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sum_accumulator
// Description : Sums BATCH adder results with saturation and holds the total
//               until the downstream stage takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_accumulator
    import adder_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned BATCH     = 4
) (
    input  wire logic       clock,
    input  wire logic       reset,
    sum_accumulator_if.slave bus
);
    localparam int unsigned c_COUNT_WIDTH = 8;
    localparam logic [c_COUNT_WIDTH-1:0] c_LAST = c_COUNT_WIDTH'(BATCH - 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [ACC_WIDTH-1:0]       r_result;
    logic [ACC_WIDTH-1:0]       w_result_next;
    logic                       r_overflow;
    logic                       w_overflow_next;
    logic [c_COUNT_WIDTH-1:0]   r_count;
    logic [c_COUNT_WIDTH-1:0]   w_count_next;

    logic [ACC_WIDTH-1:0]       w_sample;
    logic [ACC_WIDTH-1:0]       w_sat_sum;
    logic                       w_sat;

    assign w_sample = {{(ACC_WIDTH - c_SAMPLE_WIDTH){1'b0}}, bus.carryout, bus.sum};

    sat_add #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .i_a (r_result),
        .i_b (w_sample),
        .sum (w_sat_sum),
        .sat (w_sat)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_ACCUM;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_result   <= w_result_next;
            r_overflow <= w_overflow_next;
            r_count    <= w_count_next;
        end
    end

    // Priority: clear, then HOLD handshake, then accept
    always_comb begin
        w_state_next    = r_state;
        w_result_next   = r_result;
        w_overflow_next = r_overflow;
        w_count_next    = r_count;
        if (bus.clear) begin
            w_state_next    = ST_ACCUM;
            w_result_next   = '0;
            w_overflow_next = 1'b0;
            w_count_next    = '0;
        end else if (r_state == ST_HOLD) begin
            if (bus.out_ready) begin
                w_state_next    = ST_ACCUM;
                w_result_next   = '0;
                w_overflow_next = 1'b0;
                w_count_next    = '0;
            end
        end else if (bus.in_valid) begin
            w_result_next   = w_sat_sum;
            w_overflow_next = r_overflow | w_sat;
            if (r_count == c_LAST) begin
                w_state_next = ST_HOLD;
                w_count_next = '0;
            end else begin
                w_count_next = r_count + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_ACCUM);
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.result    = r_result;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter ACC_WIDTH, default 16: width of the running total and the result, legal range 10..32.
REQ-002 Parameter BATCH, default 4: number of accepted samples per result, legal range 1..255.
REQ-003 Port clock  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port in_valid  input  1: an adder result is present on sum/carryout this cycle.
REQ-006 Port in_ready  output  1: the block accepts a sample this cycle.
REQ-007 Port sum  input  8: low byte of the upstream adder result.
REQ-008 Port carryout  input  1: carry bit of the upstream adder result.
REQ-009 Port clear  input  1: abandons the current batch or result.
REQ-010 Port result  output  ACC_WIDTH: the batch total, which also shows the running total while accumulating.
REQ-011 Port overflow  output  1: the batch total saturated.
REQ-012 Port out_valid  output  1: result and overflow hold a completed batch.
REQ-013 Port out_ready  input  1: the downstream stage takes the completed batch.

Function
REQ-014 Each sample's value is the 9-bit unsigned value {carryout, sum}, range 0..511, zero-extended to ACC_WIDTH.
REQ-015 The block has two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 A sample is accepted when in_valid=1, in_ready=1 and clear=0.
REQ-017 On accept, result becomes result+sample (saturating) and the internal count increments by 1.
REQ-018 Saturating add: if the true sum exceeds 2^ACC_WIDTH-1, result becomes 2^ACC_WIDTH-1 and overflow is set to 1. Overflow stays set until the batch ends.
REQ-019 When the BATCH-th sample of a batch is accepted, the state moves from ACCUM to HOLD on that same edge. out_valid is 1 in the next cycle; latency from last accept to out_valid is 1 cycle.
REQ-020 In HOLD, result and overflow remain stable and in_valid is ignored. Dropped samples are not counted.
REQ-021 In HOLD, when out_ready=1 the state moves to ACCUM, and result, overflow and count are zeroed on that edge. No sample is accepted in the handshake cycle.
REQ-022 clear=1 in either state: the next edge goes to ACCUM with result, overflow and count zeroed. A concurrent in_valid sample is dropped and a concurrent out_ready handshake is discarded.
REQ-023 Priority, highest first: reset, clear, HOLD handshake, accept.
REQ-024 The count only runs 0..BATCH-1. It never wraps past BATCH, because HOLD is entered instead.
REQ-025 With BATCH=1, every accepted sample goes to HOLD immediately.

Reset
REQ-026 On reset=1 at a rising edge, the state goes to ACCUM, result=0, overflow=0, count=0 and out_valid=0. in_ready=1 from the next cycle.
REQ-027 Reset in the middle of a batch or in HOLD discards all partial or held data. No result is emitted.

Structure
REQ-028 The state encoding (ACCUM=0, HOLD=1) and the sample width constant (9) belong in a shared package, adder_pkg, which all adder-chain blocks use.
REQ-029 The saturating add is one sub-module, sat_add, parameterised by ACC_WIDTH, purely combinational, with outputs sum and sat.
REQ-030 The top-level holds the FSM, the count, the result and overflow registers, and the sat_add instance.

Verification
REQ-031 Reset for 2 cycles, then check: result=0, overflow=0, out_valid=0, in_ready=1.
REQ-032 Defaults, with out_ready=1 throughout. Send samples {0,16}, {0,16}, {1,0xFF}, {0,0} on consecutive cycles. Check out_valid=1 exactly 1 cycle after the 4th accept, result=543, overflow=0, then ACCUM on the next edge.
REQ-033 Hold out_ready=0 for 5 cycles after out_valid while in_valid=1 continuously. Check result stays 543, in_ready=0, and the dropped samples do not appear in the next batch total.
REQ-034 ACC_WIDTH=10: send four samples of 511. Check result=1023 and overflow=1; overflow becomes 1 on the 3rd accept and clears after the handshake.
REQ-035 Accept 2 samples, then assert clear together with in_valid. Check result=0 and count=0. The next 4 samples {0,1} give result=4.
REQ-036 Assert reset during HOLD. Check out_valid=0 and result=0 on the next edge, and no handshake occurs.
